// File: rtl/hwpe_stream_tcdm_fetch.sv
// Strided TCDM read engine: issues len word reads at base + k*stride and replays
// the responses, in order, on a 32-bit stream source through a small credit-checked FIFO.
module hwpe_stream_tcdm_fetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [31:0]          stride_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  // TCDM master
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  output logic [31:0]          tcdm_data_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  // stream source
  output logic                 stream_valid_o,
  input  logic                 stream_ready_i,
  output logic [31:0]          stream_data_o,
  output logic [3:0]           stream_strb_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          stride_q, stride_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] emitted_q, emitted_d;
  logic                 inflight_q, inflight_d;
  logic                 done_q, done_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [31:0]          mem_q [FIFO_DEPTH];

  logic req, grant, push, pop, fifo_empty, room;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check: a granted read always has a free slot waiting for its response.
  assign room       = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W+1)'(FIFO_DEPTH);
  assign fifo_empty = (count_q == '0);
  assign req        = (state_q == RUN) && (issued_q < len_q) && room;
  assign grant      = req & tcdm_gnt_i;
  assign push       = tcdm_r_valid_i & inflight_q & ~clear_i;
  assign pop        = ~fifo_empty & stream_ready_i;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    len_d      = len_q;
    issued_d   = issued_q;
    emitted_d  = emitted_q;
    inflight_d = grant;
    done_d     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop) begin
      rd_ptr_d  = ptr_inc(rd_ptr_q);
      emitted_d = emitted_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d    = base_addr_i;
          stride_d  = stride_i;
          len_d     = len_i;
          issued_d  = '0;
          emitted_d = '0;
          if (len_i != '0) state_d = RUN;
          else             done_d  = 1'b1;
        end
      end
      RUN: begin
        if (grant) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + 1'b1;
        end
        if (issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if ((emitted_q == len_q) && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a grant or response seen this cycle.
    if (clear_i) begin
      state_d    = IDLE;
      issued_d   = '0;
      emitted_d  = '0;
      inflight_d = 1'b0;
      done_d     = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      emitted_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      emitted_q  <= emitted_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tcdm_r_data_i;
  end

  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign tcdm_req_o     = req;
  assign tcdm_add_o     = addr_q;
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = 4'hF;
  assign tcdm_data_o    = '0;
  assign stream_valid_o = ~fifo_empty;
  assign stream_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign stream_strb_o  = 4'hF;

endmodule

// File: tb/tb_hwpe_stream_tcdm_fetch.sv
// Directed bench for hwpe_stream_tcdm_fetch: a job table plus hand-written sequences
// for backpressure, zero-length jobs, stray responses and mid-job clear.
module tb_hwpe_stream_tcdm_fetch;

  logic        clk_i = 1'b0;
  logic        rst_ni, clear_i, start_i;
  logic [31:0] base_addr_i, stride_i;
  logic [15:0] len_i;
  logic        busy_o, done_o;
  logic        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic [3:0]  tcdm_be_o, stream_strb_o;
  logic        stream_valid_o, stream_ready_i;
  logic [31:0] stream_data_o;

  always #5 clk_i = ~clk_i;

  hwpe_stream_tcdm_fetch #(.FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .stream_data_o(stream_data_o), .stream_strb_o(stream_strb_o)
  );

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    logic [15:0] len;
    int          gnt_pct;
    logic [31:0] exp_last;
    int          exp_lat;   // start-to-done steps at full speed, 0 = not checked
  } vec_t;

  vec_t vecs [5];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_add [64];
  int          step_no = 0;
  int          issue_idx, emit_idx, done_cnt, grant_cnt, start_step, done_step;
  int          first_grant_step, last_grant_step, first_beat_step, last_beat_step;
  logic [31:0] last_grant_add;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_data  = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_add   = '0;
  logic        req_seen;
  int          gnt_pct    = 100;
  logic        ready_mode = 1'b1;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (step %0d)", name, act, exp, step_no);
    end
  endtask

  task automatic begin_job(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] len);
    for (int i = 0; i < 64; i++) exp_add[i] = base + stride * i;
    base_addr_i = base;
    stride_i    = stride;
    len_i       = len;
    issue_idx   = 0;
    emit_idx    = 0;
    done_cnt    = 0;
    grant_cnt   = 0;
    req_seen    = 1'b0;
    start_step  = step_no + 1;
    done_step   = 0;
    first_grant_step = 0; last_grant_step = 0;
    first_beat_step  = 0; last_beat_step  = 0;
  endtask

  // One clock cycle: drive inputs at negedge, observe 1ns later, book handshakes.
  task automatic step(input logic s, input logic c);
    @(negedge clk_i);
    start_i        = s;
    clear_i        = c;
    tcdm_r_valid_i = pend_valid;
    tcdm_r_data_i  = pend_valid ? pend_data : 32'hDEAD_BEEF;
    tcdm_gnt_i     = ($urandom_range(99) < gnt_pct);
    stream_ready_i = ready_mode;
    #1;
    step_no++;
    if (prev_stall) begin
      check("req_held", {31'b0, tcdm_req_o}, 32'd1);
      check("add_stable", tcdm_add_o, prev_add);
    end
    prev_stall = tcdm_req_o && !tcdm_gnt_i && !c;
    prev_add   = tcdm_add_o;
    pend_valid = 1'b0;
    if (tcdm_req_o) req_seen = 1'b1;
    if (tcdm_req_o && tcdm_gnt_i) begin
      if (issue_idx < 64) check("add", tcdm_add_o, exp_add[issue_idx]);
      pend_valid = 1'b1;
      pend_data  = mem_f(tcdm_add_o);
      if (grant_cnt == 0) first_grant_step = step_no;
      last_grant_step = step_no;
      last_grant_add  = tcdm_add_o;
      grant_cnt++;
      issue_idx++;
    end
    if (stream_valid_o && stream_ready_i) begin
      if (emit_idx < 64) check("beat", stream_data_o, mem_f(exp_add[emit_idx]));
      if (emit_idx == 0) first_beat_step = step_no;
      last_beat_step = step_no;
      emit_idx++;
    end
    if (done_o) begin
      done_cnt++;
      done_step = step_no;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic run_vec(input int i);
    gnt_pct    = vecs[i].gnt_pct;
    ready_mode = 1'b1;
    begin_job(vecs[i].base, vecs[i].stride, vecs[i].len);
    step(1'b1, 1'b0);
    wait_done(400);
    check("done_cnt", done_cnt, 1);
    check("busy_at_done", {31'b0, busy_o}, 32'd0);
    check("grants", grant_cnt, 32'(vecs[i].len));
    check("beats", emit_idx, 32'(vecs[i].len));
    check("last_add", last_grant_add, vecs[i].exp_last);
    if (vecs[i].exp_lat != 0) begin
      check("done_latency", done_step - start_step, vecs[i].exp_lat);
      check("grant_burst", last_grant_step - first_grant_step, 32'(vecs[i].len) - 1);
      check("beat_burst", last_beat_step - first_beat_step, 32'(vecs[i].len) - 1);
    end
    step(1'b0, 1'b0);
    check("done_pulse_end", {31'b0, done_o}, 32'd0);
    $display("job %0d: base=0x%08h stride=0x%08h len=%0d grants=%0d beats=%0d done@%0d",
             i, vecs[i].base, vecs[i].stride, vecs[i].len, grant_cnt, emit_idx, done_step - start_step);
  endtask

  initial begin
    vecs[0] = '{base: 32'h0000_0100, stride: 32'h4,         len: 16'd4, gnt_pct: 100, exp_last: 32'h0000_010C, exp_lat: 8};
    vecs[1] = '{base: 32'h0000_0008, stride: 32'hFFFF_FFFC, len: 16'd3, gnt_pct: 100, exp_last: 32'h0000_0000, exp_lat: 7};
    vecs[2] = '{base: 32'hFFFF_FFF8, stride: 32'h8,         len: 16'd3, gnt_pct: 100, exp_last: 32'h0000_0008, exp_lat: 7};
    vecs[3] = '{base: 32'h0000_0200, stride: 32'h10,        len: 16'd8, gnt_pct: 50,  exp_last: 32'h0000_0270, exp_lat: 0};
    vecs[4] = '{base: 32'h0000_0040, stride: 32'h0,         len: 16'd2, gnt_pct: 100, exp_last: 32'h0000_0040, exp_lat: 6};

    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    base_addr_i = '0; stride_i = '0; len_i = '0;
    tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0; stream_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_req", {31'b0, tcdm_req_o}, 32'd0);
    check("rst_add", tcdm_add_o, 32'd0);
    check("rst_data", tcdm_data_o, 32'd0);
    check("rst_wen", {31'b0, tcdm_wen_o}, 32'd1);
    check("rst_be", {28'b0, tcdm_be_o}, 32'hF);
    check("rst_valid", {31'b0, stream_valid_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Sink stalled: only FIFO_DEPTH reads may be granted, then all 8 drain in order.
    gnt_pct = 100; ready_mode = 1'b0;
    begin_job(32'h300, 32'h4, 16'd8);
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    check("bp_grants", grant_cnt, 4);
    check("bp_req_low", {31'b0, tcdm_req_o}, 32'd0);
    check("bp_valid", {31'b0, stream_valid_o}, 32'd1);
    check("bp_no_beats", emit_idx, 0);
    ready_mode = 1'b1;
    wait_done(200);
    check("bp_done", done_cnt, 1);
    check("bp_all_grants", grant_cnt, 8);
    check("bp_all_beats", emit_idx, 8);
    $display("backpressure: grants=%0d beats=%0d done=%0d", grant_cnt, emit_idx, done_cnt);

    // Zero-length job.
    begin_job(32'h500, 32'h4, 16'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("len0_done", {31'b0, done_o}, 32'd1);
    check("len0_busy", {31'b0, busy_o}, 32'd0);
    repeat (3) step(1'b0, 1'b0);
    check("len0_done_once", done_cnt, 1);
    check("len0_no_req", {31'b0, req_seen}, 32'd0);
    $display("len0: done=%0d req_seen=%0d", done_cnt, req_seen);

    // Stray response with nothing in flight must not reach the stream.
    pend_valid = 1'b1; pend_data = 32'h1234_5678;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("stray_rvalid", {31'b0, stream_valid_o}, 32'd0);
    $display("stray r_valid: stream_valid=%0d", stream_valid_o);

    // Clear with two words buffered and a read in flight.
    ready_mode = 1'b0;
    begin_job(32'h600, 32'h4, 16'd8);
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("clr_valid", {31'b0, stream_valid_o}, 32'd0);
    check("clr_req", {31'b0, tcdm_req_o}, 32'd0);
    check("clr_busy", {31'b0, busy_o}, 32'd0);
    check("clr_done", {31'b0, done_o}, 32'd0);
    repeat (2) step(1'b0, 1'b0);
    check("clr_late_rvalid", {31'b0, stream_valid_o}, 32'd0);
    check("clr_no_done", done_cnt, 0);
    $display("clear: valid=%0d busy=%0d done_cnt=%0d", stream_valid_o, busy_o, done_cnt);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
